// File: rtl/fuzz_sig_pkg.sv
// Shared types and step functions for the fuzz stimulus/signature engine.
// Functions operate at the maximum supported widths; callers cast in and out.
package fuzz_sig_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int unsigned MAX_STIM_W = 256;
    localparam int unsigned MAX_RESP_W = 1024;

    localparam logic [62:0] DEF_LFSR_POLY = 63'h6000_0000_0000_0000;
    localparam logic [7:0]  DEF_MISR_POLY = 8'h1D;

    // Galois right-shift LFSR step; bits above the real width must be zero.
    function automatic logic [MAX_STIM_W-1:0] lfsr_step(
        input logic [MAX_STIM_W-1:0] l,
        input logic [MAX_STIM_W-1:0] poly
    );
        return (l >> 1) ^ (l[0] ? poly : '0);
    endfunction

    // Left-shift MISR step of width w; the feedback bit is sig[w-1].
    function automatic logic [MAX_RESP_W-1:0] misr_step(
        input logic [MAX_RESP_W-1:0] sig,
        input logic [MAX_RESP_W-1:0] resp,
        input logic [MAX_RESP_W-1:0] poly,
        input int unsigned           w
    );
        logic [MAX_RESP_W-1:0] mask;
        mask = {MAX_RESP_W{1'b1}} >> (MAX_RESP_W - w);
        return (((sig << 1) ^ (sig[w-1] ? poly : '0)) ^ resp) & mask;
    endfunction

endpackage

// File: rtl/fuzz_misr.sv
// RESP_W-wide multiple-input signature register with clear and enable.
// sig_next exposes the value the register takes at the coming edge.
module fuzz_misr
    import fuzz_sig_pkg::*;
#(
    parameter int unsigned        RESP_W    = 550,
    parameter logic [RESP_W-1:0]  MISR_POLY = RESP_W'(DEF_MISR_POLY)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  logic [RESP_W-1:0] resp,
    output logic [RESP_W-1:0] sig,
    output logic [RESP_W-1:0] sig_next
);

    logic [RESP_W-1:0] sig_q;

    always_comb begin
        sig_next = sig_q;
        if (clear) begin
            sig_next = '0;
        end else if (en) begin
            sig_next = RESP_W'(misr_step(MAX_RESP_W'(sig_q), MAX_RESP_W'(resp),
                                         MAX_RESP_W'(MISR_POLY), RESP_W));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_next;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/fuzz_stim_sig_engine.sv
// LFSR stimulus player plus MISR response compactor for fuzz-generated DUTs.
// Optional golden-signature comparator: define SIG_COMPARE_EN.
module fuzz_stim_sig_engine
    import fuzz_sig_pkg::*;
#(
    parameter int unsigned        STIM_W      = 63,
    parameter int unsigned        RESP_W      = 550,
    parameter int unsigned        NUM_VECTORS = 21,
    parameter int unsigned        LATENCY     = 1,
    parameter logic [STIM_W-1:0]  SEED        = STIM_W'(1),
    parameter logic [STIM_W-1:0]  LFSR_POLY   = STIM_W'(DEF_LFSR_POLY),
    parameter logic [RESP_W-1:0]  MISR_POLY   = RESP_W'(DEF_MISR_POLY)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [STIM_W-1:0] stim_o,
    output logic              stim_valid_o,
    input  logic [RESP_W-1:0] resp_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [RESP_W-1:0] signature_o,
    output logic [15:0]       vec_cnt_o
`ifdef SIG_COMPARE_EN
   ,input  logic [RESP_W-1:0] gold_sig_i,
    output logic              match_o,
    output logic              mismatch_o
`endif
);

    localparam logic [STIM_W-1:0] SEED_EFF = (SEED == '0) ? STIM_W'(1) : SEED;

    state_t            state_q, state_d;
    logic [STIM_W-1:0] lfsr_q;
    logic [31:0]       issued_q;
    logic [15:0]       vec_cnt_q;
    logic [3:0]        drain_q;
    logic              start_ok, last_vec, stim_valid, dvalid;
    logic [RESP_W-1:0] sig, sig_next;

    assign start_ok   = start && (state_q == IDLE || state_q == DONE);
    assign last_vec   = (issued_q == 32'(NUM_VECTORS - 1));
    assign stim_valid = (state_q == RUN);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = RUN;
            RUN:        if (last_vec) state_d = (LATENCY == 0) ? DONE : DRAIN;
            DRAIN:      if (drain_q == 4'(LATENCY - 1)) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // lfsr_q doubles as stim_o, so it does not step past the last vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            lfsr_q    <= '0;
            issued_q  <= '0;
            vec_cnt_q <= '0;
            drain_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        lfsr_q    <= SEED_EFF;
                        issued_q  <= '0;
                        vec_cnt_q <= '0;
                        drain_q   <= '0;
                    end
                end
                RUN: begin
                    issued_q <= issued_q + 32'd1;
                    if (vec_cnt_q != 16'hFFFF) vec_cnt_q <= vec_cnt_q + 16'd1;
                    if (!last_vec) begin
                        lfsr_q <= STIM_W'(lfsr_step(MAX_STIM_W'(lfsr_q), MAX_STIM_W'(LFSR_POLY)));
                    end
                end
                DRAIN:   drain_q <= drain_q + 4'd1;
                default: ;
            endcase
        end
    end

    if (LATENCY == 0) begin : g_nolat
        assign dvalid = stim_valid;
    end else begin : g_vpipe
        logic [LATENCY-1:0] vsr;
        always_ff @(posedge clk) begin
            if (rst) vsr <= '0;
            else     vsr <= (vsr << 1) | LATENCY'(stim_valid);
        end
        assign dvalid = vsr[LATENCY-1];
    end

    fuzz_misr #(
        .RESP_W    (RESP_W),
        .MISR_POLY (MISR_POLY)
    ) u_misr (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_ok),
        .en       (dvalid),
        .resp     (resp_i),
        .sig      (sig),
        .sig_next (sig_next)
    );

`ifdef SIG_COMPARE_EN
    logic match_q, mismatch_q;
    // Compare against sig_next: the final sample lands on the DONE-entry edge.
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            match_q    <= 1'b0;
            mismatch_q <= 1'b0;
        end else if (state_q != DONE && state_d == DONE) begin
            match_q    <= (sig_next == gold_sig_i);
            mismatch_q <= (sig_next != gold_sig_i);
        end
    end
    assign match_o    = match_q;
    assign mismatch_o = mismatch_q;
`endif

    assign stim_o       = lfsr_q;
    assign stim_valid_o = stim_valid;
    assign busy_o       = (state_q == RUN) || (state_q == DRAIN);
    assign done_o       = (state_q == DONE);
    assign signature_o  = sig;
    assign vec_cnt_o    = vec_cnt_q;

endmodule

// File: tb/tb_fuzz_stim_sig_engine.sv
// Directed bench for fuzz_stim_sig_engine: 8-bit loopback runs with hand-computed
// stimulus and signatures; comparator checks when SIG_COMPARE_EN is defined.
module tb_fuzz_stim_sig_engine;

    logic clk;
    logic rst;
    logic start, start_s0, start_l0;
    logic [7:0] stim, stim_s0, stim_l0;
    logic       valid, valid_s0, valid_l0;
    logic [7:0] resp_q, resp_s0_q;
    logic       busy, busy_s0, busy_l0;
    logic       done, done_s0, done_l0;
    logic [7:0] sig, sig_s0, sig_l0;
    logic [15:0] vcnt, vcnt_s0, vcnt_l0;
`ifdef SIG_COMPARE_EN
    logic [7:0] gold;
    logic match, mismatch, match_s0, mismatch_s0, match_l0, mismatch_l0;
`endif

    int n_vec = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        resp_q    <= stim;
        resp_s0_q <= stim_s0;
    end

    fuzz_stim_sig_engine #(
        .STIM_W(8), .RESP_W(8), .NUM_VECTORS(4), .LATENCY(1),
        .SEED(8'h01), .LFSR_POLY(8'hB8), .MISR_POLY(8'h1D)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .stim_o(stim), .stim_valid_o(valid),
        .resp_i(resp_q), .busy_o(busy), .done_o(done), .signature_o(sig),
        .vec_cnt_o(vcnt)
`ifdef SIG_COMPARE_EN
       ,.gold_sig_i(gold), .match_o(match), .mismatch_o(mismatch)
`endif
    );

    fuzz_stim_sig_engine #(
        .STIM_W(8), .RESP_W(8), .NUM_VECTORS(4), .LATENCY(1),
        .SEED(8'h00), .LFSR_POLY(8'hB8), .MISR_POLY(8'h1D)
    ) u_seed0 (
        .clk(clk), .rst(rst), .start(start_s0), .stim_o(stim_s0), .stim_valid_o(valid_s0),
        .resp_i(resp_s0_q), .busy_o(busy_s0), .done_o(done_s0), .signature_o(sig_s0),
        .vec_cnt_o(vcnt_s0)
`ifdef SIG_COMPARE_EN
       ,.gold_sig_i(gold), .match_o(match_s0), .mismatch_o(mismatch_s0)
`endif
    );

    fuzz_stim_sig_engine #(
        .STIM_W(8), .RESP_W(8), .NUM_VECTORS(1), .LATENCY(0),
        .SEED(8'h01), .LFSR_POLY(8'hB8), .MISR_POLY(8'h1D)
    ) u_lat0 (
        .clk(clk), .rst(rst), .start(start_l0), .stim_o(stim_l0), .stim_valid_o(valid_l0),
        .resp_i(stim_l0), .busy_o(busy_l0), .done_o(done_l0), .signature_o(sig_l0),
        .vec_cnt_o(vcnt_l0)
`ifdef SIG_COMPARE_EN
       ,.gold_sig_i(gold), .match_o(match_l0), .mismatch_o(mismatch_l0)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " stim"},  32'(stim),  32'h0);
        check({tag, " valid"}, 32'(valid), 32'h0);
        check({tag, " busy"},  32'(busy),  32'h0);
        check({tag, " done"},  32'(done),  32'h0);
        check({tag, " sig"},   32'(sig),   32'h0);
        check({tag, " vcnt"},  32'(vcnt),  32'h0);
    endtask

    logic [7:0] exp_stim [4];

    initial begin
        exp_stim = '{8'h01, 8'hB8, 8'h5C, 8'h2E};
        rst = 1'b1; start = 1'b0; start_s0 = 1'b0; start_l0 = 1'b0;
`ifdef SIG_COMPARE_EN
        gold = 8'h44;
`endif
        repeat (3) tick();
        check_idle_outputs("reset");
        check("reset l0 sig", 32'(sig_l0), 32'h0);
        rst = 1'b0;

        // run 1: loopback sequence and completion timing
        start = 1'b1; tick(); start = 1'b0;
        check("r1 valid", 32'(valid), 32'h1);
        check("r1 busy",  32'(busy),  32'h1);
        check("r1 vcnt0", 32'(vcnt),  32'h0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("r1 stim%0d", i), 32'(stim), 32'(exp_stim[i]));
            tick();
        end
        check("r1 drain valid", 32'(valid), 32'h0);
        check("r1 drain busy",  32'(busy),  32'h1);
        check("r1 drain stim",  32'(stim),  32'h2E);
        check("r1 drain done",  32'(done),  32'h0);
        tick();
        check("r1 done", 32'(done), 32'h1);
        check("r1 busy", 32'(busy), 32'h0);
        check("r1 sig",  32'(sig),  32'h44);
        check("r1 vcnt", 32'(vcnt), 32'h4);
`ifdef SIG_COMPARE_EN
        check("r1 match",    32'(match),    32'h1);
        check("r1 mismatch", 32'(mismatch), 32'h0);
        gold = 8'h45;
`endif

        // run 2: restart from DONE, start on 2nd RUN cycle is ignored
        start = 1'b1; tick(); start = 1'b0;
        check("r2 done clr", 32'(done), 32'h0);
`ifdef SIG_COMPARE_EN
        check("r2 match clr",    32'(match),    32'h0);
        check("r2 mismatch clr", 32'(mismatch), 32'h0);
`endif
        tick();
        start = 1'b1; tick(); start = 1'b0;
        check("r2 vcnt mid", 32'(vcnt), 32'h2);
        check("r2 stim mid", 32'(stim), 32'h5C);
        repeat (2) tick();
        check("r2 done early", 32'(done), 32'h0);
        tick();
        check("r2 done", 32'(done), 32'h1);
        check("r2 sig",  32'(sig),  32'h44);
        check("r2 vcnt", 32'(vcnt), 32'h4);
`ifdef SIG_COMPARE_EN
        check("r2 match",    32'(match),    32'h0);
        check("r2 mismatch", 32'(mismatch), 32'h1);
        gold = 8'h44;
`endif

        // run 3: reset while draining, then a clean rerun
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        check("r3 drain busy",  32'(busy),  32'h1);
        check("r3 drain valid", 32'(valid), 32'h0);
        rst = 1'b1; tick(); rst = 1'b0;
        check_idle_outputs("r3 rst");
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        check("r3 rerun done", 32'(done), 32'h1);
        check("r3 rerun sig",  32'(sig),  32'h44);

        // zero seed behaves as seed 1
        start_s0 = 1'b1; tick(); start_s0 = 1'b0;
        check("s0 stim0", 32'(stim_s0), 32'h01);
        tick();
        check("s0 stim1", 32'(stim_s0), 32'hB8);
        repeat (4) tick();
        check("s0 done", 32'(done_s0), 32'h1);
        check("s0 sig",  32'(sig_s0),  32'h44);
        check("s0 vcnt", 32'(vcnt_s0), 32'h4);

        // zero latency, single vector, combinational loopback
        start_l0 = 1'b1; tick(); start_l0 = 1'b0;
        check("l0 stim",  32'(stim_l0),  32'h01);
        check("l0 valid", 32'(valid_l0), 32'h1);
        check("l0 done early", 32'(done_l0), 32'h0);
        tick();
        check("l0 done", 32'(done_l0), 32'h1);
        check("l0 sig",  32'(sig_l0),  32'h01);
        check("l0 vcnt", 32'(vcnt_l0), 32'h1);
        check("l0 busy", 32'(busy_l0), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
